// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
//   Shared types and default sizes for the counter command sequencer.
//   cmd_op_e : 2-bit command encoding seen on cmd_op (NOP, LOAD, UP, DOWN).
//   state_e  : sequencer FSM states.
package counter_ctrl_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_STEP_W = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/counter_ctrl_step_cnt.sv
// counter_ctrl_step_cnt
//   Loadable down-counter tracking the remaining steps of an UP/DOWN command.
//   Ports:
//     clk_i       clock
//     load_i      load load_val_i this edge (takes priority over dec_i)
//     load_val_i  step count to load
//     dec_i       decrement by one this edge
//     last_step_o high while exactly one step remains
module counter_ctrl_step_cnt #(
  parameter int STEP_W = 8
) (
  input  logic              clk_i,
  input  logic              load_i,
  input  logic [STEP_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              last_step_o
);

  logic [STEP_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i) begin
      count_d = count_q - STEP_W'(1);
    end
  end

  // Pure datapath register: only consulted while the FSM is in RUN,
  // which is always entered through a load, so no reset is needed.
  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign last_step_o = (count_q == STEP_W'(1));

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
//   Command sequencer for a loadable up/down counter. Accepts NOP/LOAD/UP/DOWN
//   commands over a valid/ready handshake, drives the counter controls cycle by
//   cycle and observes the counter value to report completion, final value and
//   wrap events.
//   Ports:
//     clock, reset            clock; synchronous active-high reset
//     cmd_valid/cmd_ready     command handshake (ready only when idle)
//     cmd_op, cmd_arg         command opcode and argument (value or step count)
//     cnt_load, cnt_data_in   counter load strobe and load value
//     cnt_en, cnt_up_down     counter enable and direction (1 = up)
//     cnt_q                   current counter value
//     busy, done              not-idle flag; one-cycle completion pulse
//     final_q                 counter value captured at completion
//     wrap                    sticky wrap flag for the current/last command
//   Optional feature (macro COUNTER_SEQ_CTRL_ABORT_EN):
//     abort                   in RUN, gates cnt_en low immediately and finishes
//     aborted                 set with done when the command was aborted
module counter_seq_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter int               STEP_W  = DEF_STEP_W,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              cnt_load,
  output logic [WIDTH-1:0]  cnt_data_in,
  output logic              cnt_en,
  output logic              cnt_up_down,
  input  logic [WIDTH-1:0]  cnt_q,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  final_q,
  output logic              wrap
`ifdef COUNTER_SEQ_CTRL_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  function automatic logic wrap_hit(input logic up, input logic [WIDTH-1:0] q);
    return up ? (q == MAX_VAL) : (q == '0);
  endfunction

  state_e            state_q, state_d;
  logic              cnt_load_q, cnt_load_d;
  logic [WIDTH-1:0]  cnt_data_in_q, cnt_data_in_d;
  logic              cnt_en_q, cnt_en_d;
  logic              cnt_up_down_q, cnt_up_down_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  final_q_q, final_q_d;
  logic              wrap_q, wrap_d;
  logic              aborted_q, aborted_d;

  logic    accept;
  logic    abort_run;
  logic    run_en;
  logic    last_step;
  cmd_op_e op_in;

  assign op_in     = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

`ifdef COUNTER_SEQ_CTRL_ABORT_EN
  assign abort_run = (state_q == S_RUN) && abort;
  assign aborted   = aborted_q;
`else
  assign abort_run = 1'b0;
`endif

  // The registered enable is gated combinationally so an abort suppresses
  // the counter step in the very cycle it is raised.
  assign run_en = cnt_en_q && !abort_run;

  counter_ctrl_step_cnt #(
    .STEP_W (STEP_W)
  ) u_step_cnt (
    .clk_i       (clock),
    .load_i      (accept),
    .load_val_i  (cmd_arg),
    .dec_i       (run_en),
    .last_step_o (last_step)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (op_in)
            OP_LOAD:       state_d = S_LOAD;
            OP_UP, OP_DOWN: state_d = (cmd_arg != '0) ? S_RUN : S_DONE;
            default:       state_d = S_DONE;
          endcase
        end
      end
      S_LOAD: state_d = S_DONE;
      S_RUN:  if (abort_run || last_step) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output registers are computed from the next state so every control
  // lines up with the state it belongs to.
  always_comb begin
    cnt_load_d    = (state_d == S_LOAD);
    cnt_en_d      = (state_d == S_RUN);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    cnt_data_in_d = cnt_data_in_q;
    cnt_up_down_d = cnt_up_down_q && (state_d == S_RUN);
    final_q_d     = final_q_q;
    wrap_d        = wrap_q;
    aborted_d     = aborted_q;
    if (accept) begin
      wrap_d        = 1'b0;
      aborted_d     = 1'b0;
      cnt_up_down_d = (state_d == S_RUN) && !cmd_op[0];
      if (state_d == S_LOAD) cnt_data_in_d = cmd_arg[WIDTH-1:0];
    end
    if (run_en && wrap_hit(cnt_up_down_q, cnt_q)) wrap_d = 1'b1;
    if (abort_run) aborted_d = 1'b1;
    // Captured on leaving DONE, i.e. after the last counter edge has settled.
    if (state_q == S_DONE) final_q_d = cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_load_q    <= 1'b0;
      cnt_data_in_q <= '0;
      cnt_en_q      <= 1'b0;
      cnt_up_down_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      final_q_q     <= '0;
      wrap_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_load_q    <= cnt_load_d;
      cnt_data_in_q <= cnt_data_in_d;
      cnt_en_q      <= cnt_en_d;
      cnt_up_down_q <= cnt_up_down_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      final_q_q     <= final_q_d;
      wrap_q        <= wrap_d;
      aborted_q     <= aborted_d;
    end
  end

  assign cnt_load    = cnt_load_q;
  assign cnt_data_in = cnt_data_in_q;
  assign cnt_en      = run_en;
  assign cnt_up_down = cnt_up_down_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign final_q     = final_q_q;
  assign wrap        = wrap_q;

endmodule
